// File: rtl/trig_ctrl_pkg.sv
// rtl/trig_ctrl_pkg.sv - shared calculator defines: opcodes, core state codes, controller states
package trig_ctrl_pkg;

    localparam logic [3:0] OP_SIN = 4'h1;
    localparam logic [3:0] OP_COS = 4'h2;
    localparam logic [3:0] OP_TAN = 4'h3;

    localparam logic [2:0] COR_IDLE  = 3'd0;
    localparam logic [2:0] COR_EXECB = 3'd3;

    localparam int FRAC_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REDUCE,
        ST_CRST,
        ST_RUN,
        ST_DIV,
        ST_RESP
    } ctrl_state_t;

    function automatic logic op_supported(input logic [3:0] op);
        return (op == OP_SIN) || (op == OP_COS) || (op == OP_TAN);
    endfunction

endpackage

// File: rtl/trig_div.sv
// rtl/trig_div.sv - restoring unsigned divider, one quotient bit per cycle
module trig_div #(
    parameter int M = 24
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic [M+7:0] dividend,
    input  logic [M-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] quot,
    output logic         dz
);

    localparam int CW = $clog2(M + 1);

    logic [M-1:0]  rem_q;
    logic [M-1:0]  lo_q;
    logic [M-1:0]  q_q;
    logic [M-1:0]  dsr_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic [M:0]    shifted;
    logic [M:0]    diff;

    // rem stays below the divisor, so a borrow shows up in diff[M]
    always_comb begin
        shifted = {rem_q, lo_q[M-1]};
        diff    = shifted - {1'b0, dsr_q};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            rem_q <= '0;
            lo_q  <= '0;
            q_q   <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            dz    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q <= {{(M-8){1'b0}}, dividend[M+7:M]};
                lo_q  <= dividend[M-1:0];
                dsr_q <= divisor;
                q_q   <= '0;
                // quotient needs more than M bits when the top byte already covers the divisor
                ovf_q <= ({{(M-8){1'b0}}, dividend[M+7:M]} >= divisor);
                dz    <= (divisor == '0);
                cnt_q <= CW'(M);
                busy  <= 1'b1;
            end else if (busy) begin
                if (!diff[M]) begin
                    rem_q <= diff[M-1:0];
                    q_q   <= {q_q[M-2:0], 1'b1};
                end else begin
                    rem_q <= shifted[M-1:0];
                    q_q   <= {q_q[M-2:0], 1'b0};
                end
                lo_q  <= {lo_q[M-2:0], 1'b0};
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quot = ovf_q ? '1 : q_q;

endmodule

// File: rtl/trig_ctrl.sv
// rtl/trig_ctrl.sv - SIN/COS/TAN sequencer: angle reduction, cordic launch, sign fix, TAN divide
module trig_ctrl
    import trig_ctrl_pkg::*;
#(
    parameter int N       = 12,
    parameter int M       = 24,
    parameter int TIMEOUT = 64
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_opcode,
    input  logic [N-1:0] req_angle,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [M-1:0] rsp_result,
    output logic         rsp_err,
    output logic         cor_rst,
    output logic [2:0]   cor_state,
    output logic [3:0]   cor_opcode,
    output logic [N-1:0] cor_angle,
    input  logic [M-1:0] cor_sin,
    input  logic [M-1:0] cor_cos,
    input  logic         cor_done
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic signed [N:0] P90  = (N+1)'(90);
    localparam logic signed [N:0] N90  = -P90;
    localparam logic signed [N:0] P180 = (N+1)'(180);
    localparam logic signed [N:0] N180 = -P180;
    localparam logic signed [N:0] P360 = (N+1)'(360);
    localparam logic [M-1:0] MAX_POS = {1'b0, {(M-1){1'b1}}};
    localparam logic [M-1:0] MIN_NEG = {1'b1, {(M-1){1'b0}}};

    ctrl_state_t      state_q, state_d;
    logic signed [N:0] a_q, a_d;
    logic [3:0]       op_q, op_d;
    logic             cneg_q, cneg_d;
    logic [M-1:0]     s_q, s_d, c_q, c_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             div_go_q, div_go_d;
    logic [M-1:0]     res_d;
    logic             err_d;
    logic [N-1:0]     angle_d;
    logic [3:0]       copc_d;

    logic [M-1:0]     abs_s, abs_c, div_quot;
    logic             div_busy, div_done, div_dz, tan_neg;

    function automatic logic [M-1:0] neg_sat(input logic [M-1:0] v);
        return (v == MIN_NEG) ? MAX_POS : -v;
    endfunction

    assign req_ready = (state_q == ST_IDLE);
    assign abs_s     = s_q[M-1] ? -s_q : s_q;
    assign abs_c     = c_q[M-1] ? -c_q : c_q;
    assign tan_neg   = s_q[M-1] ^ c_q[M-1];

    trig_div #(.M(M)) u_div (
        .CLK      (CLK),
        .RST      (RST),
        .start    (div_go_q),
        .dividend ({abs_s, {FRAC_BITS{1'b0}}}),
        .divisor  (abs_c),
        .busy     (div_busy),
        .done     (div_done),
        .quot     (div_quot),
        .dz       (div_dz)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        op_d     = op_q;
        cneg_d   = cneg_q;
        s_d      = s_q;
        c_d      = c_q;
        tcnt_d   = tcnt_q;
        div_go_d = 1'b0;
        res_d    = rsp_result;
        err_d    = rsp_err;
        angle_d  = cor_angle;
        copc_d   = cor_opcode;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d   = req_opcode;
                    a_d    = {req_angle[N-1], req_angle};
                    cneg_d = 1'b0;
                    if (op_supported(req_opcode)) begin
                        copc_d  = (req_opcode == OP_TAN) ? OP_SIN : req_opcode;
                        state_d = ST_REDUCE;
                    end else begin
                        res_d   = '0;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_REDUCE: begin
                if (a_q >= P180) begin
                    a_d = a_q - P360;
                end else if (a_q < N180) begin
                    a_d = a_q + P360;
                end else begin
                    // fold into the core's half plane; cosine flips sign, sine does not
                    if (a_q > P90) begin
                        a_d    = P180 - a_q;
                        cneg_d = 1'b1;
                    end else if (a_q < N90) begin
                        a_d    = N180 - a_q;
                        cneg_d = 1'b1;
                    end
                    angle_d = a_d[N-1:0];
                    state_d = ST_CRST;
                end
            end
            ST_CRST: begin
                tcnt_d  = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cor_done) begin
                    s_d = cor_sin;
                    c_d = cneg_q ? neg_sat(cor_cos) : cor_cos;
                    case (op_q)
                        OP_SIN: begin
                            res_d   = s_d;
                            err_d   = 1'b0;
                            state_d = ST_RESP;
                        end
                        OP_COS: begin
                            res_d   = c_d;
                            err_d   = 1'b0;
                            state_d = ST_RESP;
                        end
                        default: begin
                            div_go_d = 1'b1;
                            state_d  = ST_DIV;
                        end
                    endcase
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_DIV: begin
                if (div_done && !div_busy) begin
                    err_d = div_dz;
                    if (div_dz || div_quot[M-1]) begin
                        res_d = tan_neg ? -MAX_POS : MAX_POS;
                    end else begin
                        res_d = tan_neg ? -div_quot : div_quot;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            op_q       <= '0;
            cneg_q     <= 1'b0;
            s_q        <= '0;
            c_q        <= '0;
            tcnt_q     <= '0;
            div_go_q   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            cor_rst    <= 1'b1;
            cor_state  <= COR_IDLE;
            cor_opcode <= OP_SIN;
            cor_angle  <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            op_q       <= op_d;
            cneg_q     <= cneg_d;
            s_q        <= s_d;
            c_q        <= c_d;
            tcnt_q     <= tcnt_d;
            div_go_q   <= div_go_d;
            rsp_valid  <= (state_d == ST_RESP);
            rsp_result <= res_d;
            rsp_err    <= err_d;
            cor_rst    <= (state_d == ST_IDLE) || (state_d == ST_CRST);
            cor_state  <= (state_d == ST_RUN) ? COR_EXECB : COR_IDLE;
            cor_opcode <= copc_d;
            cor_angle  <= angle_d;
        end
    end

endmodule

// File: tb/tb_trig_ctrl.sv
// tb/tb_trig_ctrl.sv - scoreboard bench for trig_ctrl with a behavioural core stand-in
module tb_trig_ctrl;
    import trig_ctrl_pkg::*;

    localparam int N       = 12;
    localparam int M       = 24;
    localparam int TIMEOUT = 64;

    logic         CLK = 1'b0;
    logic         RST;
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_opcode;
    logic [N-1:0] req_angle;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [M-1:0] rsp_result;
    logic         rsp_err;
    logic         cor_rst;
    logic [2:0]   cor_state;
    logic [3:0]   cor_opcode;
    logic [N-1:0] cor_angle;
    logic [M-1:0] cor_sin;
    logic [M-1:0] cor_cos;
    logic         cor_done;

    trig_ctrl #(.N(N), .M(M), .TIMEOUT(TIMEOUT)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_angle  (req_angle),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .cor_rst    (cor_rst),
        .cor_state  (cor_state),
        .cor_opcode (cor_opcode),
        .cor_angle  (cor_angle),
        .cor_sin    (cor_sin),
        .cor_cos    (cor_cos),
        .cor_done   (cor_done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]   op;
        int           angle;
        logic [M-1:0] s;
        logic [M-1:0] c;
        int           ang;
        int           ncyc;
        logic [M-1:0] res;
        logic         err;
    } vec_t;

    vec_t         vecs[13];
    logic [M:0]   exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [M-1:0] core_sin_v = '0;
    logic [M-1:0] core_cos_v = '0;
    int           core_lat   = 4;
    logic         core_stuck = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // core stand-in: answers core_lat cycles into EXECB unless stuck
    initial begin
        int run_cnt = 0;
        cor_done = 1'b0;
        cor_sin  = '0;
        cor_cos  = '0;
        forever begin
            @(posedge CLK); #1;
            cor_done = 1'b0;
            if (cor_state == COR_EXECB && !cor_rst) begin
                run_cnt++;
                if (!core_stuck && run_cnt == core_lat) begin
                    cor_done = 1'b1;
                    cor_sin  = core_sin_v;
                    cor_cos  = core_cos_v;
                end
            end else begin
                run_cnt = 0;
            end
        end
    end

    initial begin
        logic [M:0] e;
        forever begin
            @(negedge CLK);
            if (RST && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got result 0x%0h, expected no response", rsp_result);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_result", 32'(rsp_result), 32'(e[M-1:0]));
                    check("rsp_err", 32'(rsp_err), 32'(e[M]));
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input int ang);
        int n = 0;
        while (!req_ready && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!req_ready) bound_fail("issue_ready");
        req_valid  = 1'b1;
        req_opcode = op;
        req_angle  = ang[N-1:0];
        @(posedge CLK); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (cor_state != COR_EXECB && n < 60) begin
            @(posedge CLK); #1;
            n++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 400) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 400) bound_fail("wait_idle");
    endtask

    task automatic run_vec(input vec_t v);
        int           n;
        logic [N-1:0] ea;
        logic [3:0]   eop;
        ea         = v.ang[N-1:0];
        eop        = (v.op == OP_TAN) ? OP_SIN : v.op;
        core_sin_v = v.s;
        core_cos_v = v.c;
        exp_q.push_back({v.err, v.res});
        issue(v.op, v.angle);
        wait_run(n);
        check("run_entry_cycles", 32'(n), 32'(v.ncyc));
        check("cor_angle", 32'(cor_angle), 32'(ea));
        check("cor_opcode", 32'(cor_opcode), 32'(eop));
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0]  = '{OP_SIN,   30, 24'h000080, 24'h0000DE,  30, 2, 24'h000080, 1'b0};
        vecs[1]  = '{OP_COS,  120, 24'h0000DE, 24'h000080,  60, 2, 24'hFFFF80, 1'b0};
        vecs[2]  = '{OP_SIN,  390, 24'h000080, 24'h0000DE,  30, 3, 24'h000080, 1'b0};
        vecs[3]  = '{OP_TAN,   45, 24'h0000B5, 24'h0000B5,  45, 2, 24'h000100, 1'b0};
        vecs[4]  = '{OP_TAN,  -45, 24'hFFFF4B, 24'h0000B5, -45, 2, 24'hFFFF00, 1'b0};
        vecs[5]  = '{OP_TAN,   90, 24'h000100, 24'h000000,  90, 2, 24'h7FFFFF, 1'b1};
        vecs[6]  = '{OP_COS,  180, 24'h000000, 24'h800000,   0, 3, 24'h7FFFFF, 1'b0};
        vecs[7]  = '{OP_COS, 2047, 24'h0000EC, 24'h000064, -67, 8, 24'hFFFF9C, 1'b0};
        vecs[8]  = '{OP_SIN, -2048, 24'h0000ED, 24'h000060, 68, 8, 24'h0000ED, 1'b0};
        vecs[9]  = '{OP_TAN, -135, 24'hFFFF4B, 24'h0000B5, -45, 2, 24'h000100, 1'b0};
        vecs[10] = '{OP_TAN,   89, 24'h7FFFFF, 24'hFFFFFF,  89, 2, 24'h800001, 1'b0};
        vecs[11] = '{OP_TAN,   60, 24'h0000DE, 24'h000080,  60, 2, 24'h0001BC, 1'b0};
        vecs[12] = '{OP_COS, -180, 24'h000000, 24'h000100,   0, 2, 24'hFFFF00, 1'b0};

        RST        = 1'b0;
        req_valid  = 1'b0;
        req_opcode = 4'h0;
        req_angle  = '0;
        rsp_ready  = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_result", 32'(rsp_result), 32'd0);
        check("reset_cor_rst", 32'(cor_rst), 32'd1);
        check("reset_cor_state", 32'(cor_state), 32'(COR_IDLE));
        check("reset_cor_opcode", 32'(cor_opcode), 32'(OP_SIN));
        check("reset_req_ready", 32'(req_ready), 32'd1);
        RST = 1'b1;
        @(posedge CLK); #1;
        check("release_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            core_lat = 3 + (i % 3);
            run_vec(vecs[i]);
        end

        // reset in the middle of RUN drops the request without a response
        core_lat = 30;
        core_sin_v = 24'h000055;
        issue(OP_COS, 45);
        wait_run(n);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        #2;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_rsp_result", 32'(rsp_result), 32'd0);
        check("midrst_rsp_err", 32'(rsp_err), 32'd0);
        check("midrst_cor_rst", 32'(cor_rst), 32'd1);
        check("midrst_cor_state", 32'(cor_state), 32'(COR_IDLE));
        check("midrst_cor_opcode", 32'(cor_opcode), 32'(OP_SIN));
        check("midrst_cor_angle", 32'(cor_angle), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        @(posedge CLK); #1;
        RST = 1'b1;
        core_lat = 4;
        run_vec(vecs[0]);

        // unsupported opcode, response held while the consumer stalls
        rsp_ready = 1'b0;
        exp_q.push_back({1'b1, {M{1'b0}}});
        issue(4'hF, 5);
        check("unsup_latency_valid", 32'(rsp_valid), 32'd1);
        req_valid  = 1'b1;
        req_opcode = OP_SIN;
        req_angle  = 12'd10;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_result", 32'(rsp_result), 32'd0);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();

        // core never answers
        core_stuck = 1'b1;
        exp_q.push_back({1'b1, {M{1'b0}}});
        issue(OP_SIN, 10);
        wait_run(n);
        if (cor_state != COR_EXECB) bound_fail("timeout_run_entry");
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(TIMEOUT));
        wait_idle();
        core_stuck = 1'b0;

        repeat (3) @(posedge CLK);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
